// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive queue.
package uart_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int RX_DATA_W = 8;

  typedef struct packed {
    logic                 err;
    logic [RX_DATA_W-1:0] data;
  } rx_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
    if (cnt == {ERR_CNT_W{1'b1}}) begin
      err_cnt_inc = cnt;
    end else begin
      err_cnt_inc = cnt + ERR_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-side and consumer-side signals of the UART receive queue.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  import uart_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_error;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [LVL_W-1:0]      level;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  overrun;
  logic [ERR_CNT_W-1:0]  err_cnt;
  logic                  stats_clr;

  modport master (
    output rx_data, rx_valid, rx_error, out_ready, stats_clr,
    input  out_data, out_err, out_valid, level, empty, full, almost_full, overrun, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid, rx_error, out_ready, stats_clr,
    output out_data, out_err, out_valid, level, empty, full, almost_full, overrun, err_cnt
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead synchronous FIFO with wrap-bit pointers and an occupancy count.
module uart_sync_fifo #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic             push_s, pop_s;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign almost_full = (level_q >= PW'(AF_LEVEL));
  assign level       = level_q;
  assign rd_data     = mem[rd_ptr_q[AW-1:0]];

  // A write into a full queue is only taken when the head leaves in the same cycle.
  assign pop_s  = rd_en & ~empty;
  assign push_s = wr_en & (~full | pop_s);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive queue: tags each character with its error flag and tracks overrun/error statistics.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);

  logic [DATA_WIDTH:0]   wr_entry_s, rd_entry_s;
  logic                  empty_s, full_s;
  logic                  drop_s, err_evt_s;
  logic                  overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d, err_base_s;

  assign wr_entry_s = {bus.rx_error, bus.rx_data};

  uart_sync_fifo #(
    .WIDTH    (DATA_WIDTH + 1),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (bus.rx_valid),
    .wr_data     (wr_entry_s),
    .rd_en       (bus.out_ready),
    .rd_data     (rd_entry_s),
    .empty       (empty_s),
    .full        (full_s),
    .almost_full (bus.almost_full),
    .level       (bus.level)
  );

  assign bus.out_valid = ~empty_s;
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.out_data  = rd_entry_s[DATA_WIDTH-1:0];
  assign bus.out_err   = rd_entry_s[DATA_WIDTH];
  assign bus.overrun   = overrun_q;
  assign bus.err_cnt   = err_cnt_q;

  // Dropped characters still count as errors if tagged.
  assign drop_s    = bus.rx_valid & full_s & ~(bus.out_ready & ~empty_s);
  assign err_evt_s = bus.rx_valid & bus.rx_error;

  // Statistics next-state: a clear and a same-cycle event leave the event's effect.
  always_comb begin
    overrun_d  = overrun_q;
    err_cnt_d  = err_cnt_q;
    err_base_s = bus.stats_clr ? {ERR_CNT_W{1'b0}} : err_cnt_q;
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (bus.stats_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (err_evt_s) begin
      err_cnt_d = err_cnt_inc(err_base_s);
    end else begin
      err_cnt_d = err_base_s;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences, random traffic vs. a queue model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  rx_entry_t mq[$];
  bit        m_ov;
  int        m_cnt;

  typedef struct {
    bit         rv;
    bit         re;
    logic [7:0] d;
    bit         rdy;
    bit         clr;
    bit         rn;
    int         lvl;
    bit         vld;
    logic [7:0] dat;
    bit         er;
    bit         ov;
    int         cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("level", bus.level, mq.size());
    chk("empty", bus.empty, mq.size() == 0);
    chk("full", bus.full, mq.size() == DEPTH);
    chk("almost_full", bus.almost_full, mq.size() >= AFL);
    chk("out_valid", bus.out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_data", bus.out_data, mq[0].data);
      chk("out_err", bus.out_err, mq[0].err);
    end
    chk("overrun", bus.overrun, m_ov);
    chk("err_cnt", bus.err_cnt, m_cnt);
  endtask

  // Drive one cycle, advance the model by the same rules, then compare everything.
  task automatic apply(input bit rv, input bit re, input logic [7:0] d,
                       input bit rdy, input bit clr, input bit rn);
    bit        pop, push;
    int        base;
    rx_entry_t e, tmp;
    bus.rx_valid  = rv;
    bus.rx_error  = re;
    bus.rx_data   = d;
    bus.out_ready = rdy;
    bus.stats_clr = clr;
    rst_n         = rn;
    if (!rn) begin
      mq.delete();
      m_ov  = 1'b0;
      m_cnt = 0;
    end else begin
      pop  = rdy && (mq.size() > 0);
      push = rv && ((mq.size() < DEPTH) || pop);
      base = clr ? 0 : m_cnt;
      if (rv && re && base < 255) base++;
      m_cnt = base;
      m_ov  = (clr ? 1'b0 : m_ov) | (rv && !push);
      if (pop) tmp = mq.pop_front();
      if (push) begin
        e.err  = re;
        e.data = d;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.rx_data = 8'h00;
    bus.out_ready = 1'b0; bus.stats_clr = 1'b0; rst_n = 1'b0;

    //          rv  re  d      rdy clr rn   lvl vld dat    er  ov  cnt
    tbl[0]  = '{0,  0,  8'h00, 0,  0,  0,   0,  0,  8'h00, 0,  0,  0};
    tbl[1]  = '{1,  0,  8'h55, 0,  0,  1,   1,  1,  8'h55, 0,  0,  0};
    tbl[2]  = '{1,  1,  8'h3C, 0,  0,  1,   2,  1,  8'h55, 0,  0,  1};
    tbl[3]  = '{0,  0,  8'h00, 1,  0,  1,   1,  1,  8'h3C, 1,  0,  1};
    tbl[4]  = '{1,  0,  8'h11, 1,  0,  1,   1,  1,  8'h11, 0,  0,  1};
    tbl[5]  = '{0,  0,  8'h00, 0,  1,  1,   1,  1,  8'h11, 0,  0,  0};
    tbl[6]  = '{1,  1,  8'h22, 0,  1,  1,   2,  1,  8'h11, 0,  0,  1};
    tbl[7]  = '{0,  0,  8'h00, 1,  0,  1,   1,  1,  8'h22, 1,  0,  1};
    tbl[8]  = '{0,  0,  8'h00, 1,  0,  1,   0,  0,  8'h00, 0,  0,  1};
    tbl[9]  = '{1,  0,  8'h99, 1,  0,  1,   1,  1,  8'h99, 0,  0,  1};
    tbl[10] = '{1,  1,  8'hAA, 0,  0,  0,   0,  0,  8'h00, 0,  0,  0};
    tbl[11] = '{0,  0,  8'h00, 0,  0,  1,   0,  0,  8'h00, 0,  0,  0};

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rv, tbl[i].re, tbl[i].d, tbl[i].rdy, tbl[i].clr, tbl[i].rn);
      chk($sformatf("tbl%0d_level", i), bus.level, tbl[i].lvl);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].dat);
        chk($sformatf("tbl%0d_err", i), bus.out_err, tbl[i].er);
      end
      chk($sformatf("tbl%0d_overrun", i), bus.overrun, tbl[i].ov);
      chk($sformatf("tbl%0d_errcnt", i), bus.err_cnt, tbl[i].cnt);
    end

    // Fill to full, overflow, drain in order.
    apply(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      apply(1, 0, 8'(i), 0, 0, 1);
      if (i == 10) chk("af_at_11", bus.almost_full, 1'b0);
      if (i == 11) chk("af_at_12", bus.almost_full, 1'b1);
    end
    apply(1, 0, 8'hAA, 0, 0, 1);
    chk("ovf_full", bus.full, 1'b1);
    chk("ovf_overrun", bus.overrun, 1'b1);
    chk("ovf_level", bus.level, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", bus.out_data, i);
      apply(0, 0, 8'h00, 1, 0, 1);
    end
    chk("drain_empty", bus.empty, 1'b1);

    // Push and pop together while full.
    apply(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) apply(1, 0, 8'(i), 0, 0, 1);
    apply(1, 0, 8'h77, 1, 0, 1);
    chk("pp_full_level", bus.level, 16);
    chk("pp_full_overrun", bus.overrun, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("pp_drain", bus.out_data, (i < 15) ? (i + 1) : 32'h77);
      apply(0, 0, 8'h00, 1, 0, 1);
    end

    // Clear racing a dropped error character.
    apply(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) apply(1, (i < 5), 8'(i), 0, 0, 1);
    apply(1, 0, 8'hEE, 0, 0, 1);
    chk("pre_clr_overrun", bus.overrun, 1'b1);
    chk("pre_clr_errcnt", bus.err_cnt, 5);
    apply(1, 1, 8'h33, 0, 1, 1);
    chk("clr_race_overrun", bus.overrun, 1'b1);
    chk("clr_race_errcnt", bus.err_cnt, 1);

    // Error counter saturation.
    apply(0, 0, 8'h00, 0, 1, 1);
    for (int k = 0; k < 300; k++) begin
      apply(1, 1, 8'(k), 1, 0, 1);
      if (k == 253) chk("errcnt_254", bus.err_cnt, 254);
    end
    chk("errcnt_sat", bus.err_cnt, 255);

    // Traffic across pointer wrap, then reset with entries held.
    apply(0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 40; k++) apply(1, 0, 8'($urandom), (k >= 3), 0, 1);
    for (int k = 0; k < 4; k++) apply(1, 0, 8'($urandom), 0, 0, 1);
    chk("pre_rst_level", bus.level, 7);
    apply(1, 0, 8'h5A, 0, 0, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_valid", bus.out_valid, 1'b0);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      apply(($urandom_range(0, 99) < 60), ($urandom_range(0, 9) == 0), 8'($urandom),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 299) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of received character.
REQ-002 Parameter DEPTH, default 16, entry count; power of two, 4..256.
REQ-003 Parameter AF_LEVEL, default 12, almost_full threshold in entries, 1..DEPTH.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rx_data  input  DATA_WIDTH  character from UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe qualifying rx_data/rx_error.
REQ-008 rx_error  input  1  framing/parity error flag for the same character.
REQ-009 out_data  output  DATA_WIDTH  head-of-queue character.
REQ-010 out_err  output  1  error flag stored with head character.
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 empty, full, almost_full  output  1 each  status flags.
REQ-015 overrun  output  1  sticky: character dropped because full.
REQ-016 err_cnt  output  8  saturating count of error-tagged characters received.
REQ-017 stats_clr  input  1  clears overrun and err_cnt.

Function
REQ-018 Push occurs when rx_valid=1 and (full=0 or pop in same cycle); entry = {rx_error, rx_data}.
REQ-019 Pop occurs when out_valid=1 and out_ready=1.
REQ-020 Show-ahead: out_data/out_err reflect head entry combinationally from storage whenever out_valid=1.
REQ-021 Write-to-read latency 1 cycle: push into empty FIFO at edge N yields out_valid=1 after edge N.
REQ-022 out_valid SHALL equal !empty; out_data/out_err are don't-care when out_valid=0.
REQ-023 Pointers are $clog2(DEPTH)+1 bits with wrap bit; full when addresses equal and wrap bits differ; empty when fully equal.
REQ-024 level increments on push-only, decrements on pop-only, unchanged on push+pop or neither.
REQ-025 almost_full = (level >= AF_LEVEL); all flags registered or derived from registered pointers only.
REQ-026 rx_valid=1 while full with no simultaneous pop: character discarded, pointers unchanged, overrun set next cycle.
REQ-027 Simultaneous push and pop while full: push accepted, level stays DEPTH, overrun not set.
REQ-028 Simultaneous push and pop while empty: pop not possible (out_valid=0); push accepted, level becomes 1.
REQ-029 err_cnt increments by 1 on every rx_valid with rx_error=1, including dropped characters; saturates at 255.
REQ-030 stats_clr=1 clears overrun and err_cnt next cycle; simultaneous set event wins (overrun=1, err_cnt=1).
REQ-031 Pointers wrap modulo DEPTH without loss; no ordering change across wrap.

Reset
REQ-032 On clk edge with rst_n=0: pointers 0, level 0, empty=1, full=0, almost_full=0, out_valid=0, overrun=0, err_cnt=0.
REQ-033 Reset mid-operation discards all stored entries; storage array is not cleared.
REQ-034 rx_valid during reset is ignored.

Structure
REQ-035 Shared package uart_pkg holds typedef rx_entry_t {err, data} and constant ERR_CNT_W=8.
REQ-036 Storage and pointer logic in one sub-module uart_sync_fifo (generic width/depth); uart_rx_fifo adds overrun, err_cnt, stats.
REQ-037 Storage inferable as distributed RAM/registers; no asynchronous reset on array.

Verification (DEPTH=16, AF_LEVEL=12)
REQ-038 Push 0x55 with out_ready=0 -> next cycle out_valid=1, out_data=0x55, level=1, empty=0.
REQ-039 Push 16 chars 0x00..0x0F, then 17th 0xAA -> full=1, almost_full=1 from level 12, overrun=1, drain returns 0x00..0x0F, 0xAA never appears.
REQ-040 Full FIFO, out_ready=1 and rx_valid=1 (0x77) same cycle -> level stays 16, overrun=0, 0x77 read last.
REQ-041 Push 0x3C with rx_error=1 -> out_err=1 on that entry, err_cnt=1; 300 error pushes -> err_cnt=255.
REQ-042 overrun=1, err_cnt=5; stats_clr=1 with simultaneous error push while full -> overrun=1, err_cnt=1.
REQ-043 40 push/pop cycles across pointer wrap then rst_n=0 one cycle with level=7 -> order preserved before reset; after reset level=0, empty=1, out_valid=0.
